// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiply sequencer that borrows the shared EX-stage ALU
module alu_mul_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SLL = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [4:0]       alu_shamt,
  output logic             alu_own,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic             last_shift;

  // The shift in progress retires the last multiplier bit, or the final bit position was reached.
  assign last_shift = (mplier[WIDTH-1:1] == '0) || (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_b == '0)  next_state = S_DONE;
          else if (op_b[0]) next_state = S_ADD;
          else              next_state = S_SHIFT;
        end
      end
      S_ADD:   next_state = S_SHIFT;
      S_SHIFT: begin
        if (last_shift)     next_state = S_DONE;
        else if (mplier[1]) next_state = S_ADD;
        else                next_state = S_SHIFT;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    alu_ctrl  = OP_ADD;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_shamt = 5'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_ADD: begin
        alu_op1 = acc;
        alu_op2 = mcand;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        alu_ctrl  = OP_SLL;
        alu_op1   = mcand;
        alu_shamt = 5'd1;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    alu_own = busy;
    stall   = busy | ((state == S_IDLE) & start);
  end

  // product is loaded on the edge into DONE so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            count  <= '0;
            if (op_b == '0) product <= '0;
          end
        end
        S_ADD: acc <= alu_result;
        S_SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_shift) product <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - self-checking bench for alu_mul_sequencer with a behavioural ALU
module tb_alu_mul_sequencer;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_shamt;
  logic        alu_own;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  assign alu_result = (alu_ctrl == OP_ADD) ? alu_op1 + alu_op2 :
                      (alu_ctrl == OP_SLL) ? alu_op1 << alu_shamt : 32'h0;

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .alu_result(alu_result), .alu_ctrl(alu_ctrl), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_shamt(alu_shamt), .alu_own(alu_own),
    .stall(stall), .busy(busy), .done(done), .product(product)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_latency(input logic [31:0] b);
    int msb = 0;
    if (b == 32'h0) return 1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    return 1 + $countones(b) + msb + 1;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ep,
                        input int el, input bit pulse_mid, input bit hold);
    logic [2:0] seq[$];
    int lat;
    int idx;
    for (int i = 0; i < 32; i++) begin
      if ((b >> i) != 32'h0) begin
        if (b[i]) seq.push_back(OP_ADD);
        seq.push_back(OP_SLL);
      end
    end
    start = 1'b1; op_a = a; op_b = b;
    #1 check("stall_on_request", {31'h0, stall}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    start = hold; op_a = $urandom; op_b = $urandom;
    lat = 1; idx = 0;
    while (!done && lat <= 200) begin
      if (idx < seq.size()) begin
        check("alu_ctrl_seq", {29'h0, alu_ctrl}, {29'h0, seq[idx]});
        if (seq[idx] == OP_SLL) check("shamt_in_shift", {27'h0, alu_shamt}, 32'h1);
      end else begin
        n_checks++; n_errors++;
        $display("FAIL extra_busy_cycle: got busy cycle %0d expected at most %0d", lat, seq.size());
      end
      check("busy_while_owning", {31'h0, busy}, 32'h1);
      check("alu_own_while_busy", {31'h0, alu_own}, 32'h1);
      check("stall_while_busy", {31'h0, stall}, 32'h1);
      idx++;
      if (pulse_mid && lat == 2) begin start = 1'b1; op_a = $urandom; op_b = $urandom; end
      if (pulse_mid && lat == 3) start = hold;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    check("latency", lat, el);
    check("product_at_done", product, ep);
    check("busy_in_done", {31'h0, busy}, 32'h0);
    check("alu_own_in_done", {31'h0, alu_own}, 32'h0);
    check("stall_in_done", {31'h0, stall}, 32'h0);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("product_held", product, ep);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    vecs[0] = '{32'd5, 32'd7, 32'd35, 7};
    vecs[1] = '{32'h12345678, 32'h0, 32'h0, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 65};
    vecs[3] = '{32'h80000000, 32'd2, 32'h0, 4};
    vecs[4] = '{32'd3, 32'd8, 32'd24, 6};

    rst = 1'b0; start = 1'b0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_product", product, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_alu_own", {31'h0, alu_own}, 32'h0);
    check("reset_alu_ctrl", {29'h0, alu_ctrl}, {29'h0, OP_ADD});
    rst = 1'b1;

    for (int i = 0; i < 5; i++) do_mul(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat, 1'b0, 1'b0);

    // Mid-operation start is ignored; then a start held through done is taken in the next IDLE.
    do_mul(32'd6, 32'd9, 32'd54, 7, 1'b1, 1'b0);
    do_mul(32'd7, 32'd11, 32'd77, model_latency(32'd11), 1'b0, 1'b1);
    do_mul(32'd3, 32'd8, 32'd24, 6, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_mul(ra, rb, ra * rb, model_latency(rb), 1'b0, 1'b0);
    end

    // Reset during the 10th busy cycle of the all-ones multiply.
    do_mul(32'd5, 32'd7, 32'd35, 7, 1'b0, 1'b0);
    start = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_reset", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_product", product, 32'h0);
    check("midrst_alu_ctrl", {29'h0, alu_ctrl}, {29'h0, OP_ADD});
    check("midrst_op1", alu_op1, 32'h0);
    check("midrst_op2", alu_op2, 32'h0);
    check("midrst_alu_own", {31'h0, alu_own}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_mul(32'd5, 32'd7, 32'd35, 7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
